seq_shift_add_multiplier: RTL and testbench

//  Parametrised sequential radix-2 shift-add multiplier. Successor to the 4x4

---
 rtl/seq_shift_add_multiplier_if.sv | 28 ++
 rtl/seq_shift_add_multiplier.sv | 125 ++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// Handshake/data bundle for the sequential shift-add multiplier.
//   start        requester -> multiplier : operation request (sampled in IDLE)
//   signed_mode  requester -> multiplier : 1 = two's-complement operands
//   a, b         requester -> multiplier : multiplicand / multiplier
//   busy         multiplier -> requester : operation in flight
//   done         multiplier -> requester : one-cycle completion pulse
//   product      multiplier -> requester : 2*WIDTH-bit result, held until next done
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// One partial-product add per clock; signed operands are handled by
// multiplying magnitudes and negating the result when the signs differ.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts an operation in flight)
//   bus    seq_shift_add_multiplier_if.slave: start/signed_mode/a/b in,
//          busy/done/product out (all outputs come from registers)
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | WIDTH add/shift steps, one multiplier bit per edge
// FIN   | apply sign, publish product, pulse done
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seq_shift_add_multiplier_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mult_q, mult_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       addend, sum;

  // The most negative operand negates to itself, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1), so no extra bit is needed here.
  always_comb begin
    mag_a = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // Upper half plus multiplicand with the carry kept; the carry becomes the
  // new MSB once the accumulator shifts right.
  always_comb begin
    addend = mult_q[0] ? {1'b0, mcand_q} : '0;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mult_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = mag_a;
          mult_d  = mag_b;
          neg_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d  = {sum, acc_q[WIDTH-1:1]};
        mult_d = mult_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end

      FIN: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: a 4-bit and an 8-bit instance
// share clock and reset.
module tb_seq_shift_add_multiplier;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  seq_shift_add_multiplier_if #(.WIDTH(4)) if4 ();
  seq_shift_add_multiplier_if #(.WIDTH(8)) if8 ();

  seq_shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tsm,
                     output logic [7:0] prod, output int lat);
    @(negedge clk);
    if4.start       = 1'b1;
    if4.a           = ta;
    if4.b           = tb;
    if4.signed_mode = tsm;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    chk("w4_busy_after_start", {31'b0, if4.busy}, 32'd1);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (if4.done) break;
    end
    prod = if4.product;
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                     output logic [15:0] prod, output int lat);
    @(negedge clk);
    if8.start       = 1'b1;
    if8.a           = ta;
    if8.b           = tb;
    if8.signed_mode = tsm;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (if8.done) break;
    end
    prod = if8.product;
  endtask

  initial begin
    logic [7:0]  p4;
    logic [15:0] p8;
    int          lat;
    int          ua, ub, sa, sb, pr;
    logic        seen;

    checks   = 0;
    failures = 0;

    vecs[0] = '{a: 4'd15, b: 4'd15, sm: 1'b0, exp: 8'd225};
    vecs[1] = '{a: 4'h8,  b: 4'h8,  sm: 1'b1, exp: 8'h40};
    vecs[2] = '{a: 4'h8,  b: 4'h7,  sm: 1'b1, exp: 8'hC8};
    vecs[3] = '{a: 4'hF,  b: 4'h1,  sm: 1'b1, exp: 8'hFF};
    vecs[4] = '{a: 4'h0,  b: 4'h8,  sm: 1'b1, exp: 8'h00};
    vecs[5] = '{a: 4'd3,  b: 4'd5,  sm: 1'b0, exp: 8'd15};
    vecs[6] = '{a: 4'd7,  b: 4'd9,  sm: 1'b0, exp: 8'd63};
    vecs[7] = '{a: 4'h8,  b: 4'h8,  sm: 1'b0, exp: 8'd64};
    vecs[8] = '{a: 4'hF,  b: 4'hF,  sm: 1'b1, exp: 8'h01};
    vecs[9] = '{a: 4'h7,  b: 4'hD,  sm: 1'b1, exp: 8'hEB};

    rst_n            = 1'b0;
    if4.start        = 1'b0;
    if4.signed_mode  = 1'b0;
    if4.a            = '0;
    if4.b            = '0;
    if8.start        = 1'b0;
    if8.signed_mode  = 1'b0;
    if8.a            = '0;
    if8.b            = '0;

    #12;
    chk("reset_w4_busy",    {31'b0, if4.busy}, 32'd0);
    chk("reset_w4_done",    {31'b0, if4.done}, 32'd0);
    chk("reset_w4_product", {24'b0, if4.product}, 32'd0);
    chk("reset_w8_busy",    {31'b0, if8.busy}, 32'd0);
    chk("reset_w8_product", {16'b0, if8.product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 10; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].sm, p4, lat);
      chk($sformatf("vec%0d_product", i), {24'b0, p4}, {24'b0, vecs[i].exp});
      chk($sformatf("vec%0d_latency", i), lat, 32'd5);
    end

    // exhaustive unsigned and signed, reference from integer arithmetic
    for (int i = 0; i < 256; i++) begin
      ua = i / 16;
      ub = i % 16;
      op4(4'(ua), 4'(ub), 1'b0, p4, lat);
      pr = ua * ub;
      chk($sformatf("unsigned_%0d_%0d", ua, ub), {24'b0, p4}, pr & 255);
      chk("unsigned_latency", lat, 32'd5);
    end
    for (int i = 0; i < 256; i++) begin
      ua = i / 16;
      ub = i % 16;
      sa = (ua >= 8) ? ua - 16 : ua;
      sb = (ub >= 8) ? ub - 16 : ub;
      op4(4'(ua), 4'(ub), 1'b1, p4, lat);
      pr = sa * sb;
      chk($sformatf("signed_%0d_%0d", sa, sb), {24'b0, p4}, pr & 255);
      chk("signed_latency", lat, 32'd5);
    end

    // start re-pulsed with new operands during RUN is ignored
    @(negedge clk);
    if4.start       = 1'b1;
    if4.a           = 4'd5;
    if4.b           = 4'd6;
    if4.signed_mode = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      #1;
      if4.start       = 1'b1;
      if4.a           = 4'(k + 8);
      if4.b           = 4'(15 - k);
      if4.signed_mode = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("ignore_start_no_done_edge%0d", k), {31'b0, if4.done}, 32'd0);
    end
    if4.start = 1'b0;
    @(posedge clk);
    #1;
    chk("ignore_start_done",    {31'b0, if4.done}, 32'd1);
    chk("ignore_start_product", {24'b0, if4.product}, 32'd30);
    @(posedge clk);
    #1;
    chk("ignore_start_single_done", {31'b0, if4.done}, 32'd0);
    chk("ignore_start_idle",        {31'b0, if4.busy}, 32'd0);

    // start held high: accept at edge 0, done after edge 5, re-accept at
    // edge 6 with the new operands, done after edge 11
    @(negedge clk);
    if4.start       = 1'b1;
    if4.a           = 4'd3;
    if4.b           = 4'd5;
    if4.signed_mode = 1'b0;
    @(posedge clk);
    #1;
    if4.a = 4'd7;
    if4.b = 4'd9;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("held_done_edge%0d", e), {31'b0, if4.done},
          (e == 5 || e == 11) ? 32'd1 : 32'd0);
      chk($sformatf("held_busy_edge%0d", e), {31'b0, if4.busy},
          (e == 5 || e == 11) ? 32'd0 : 32'd1);
      if (e == 5)  chk("held_product_first",  {24'b0, if4.product}, 32'd15);
      if (e == 11) chk("held_product_second", {24'b0, if4.product}, 32'd63);
    end
    if4.start = 1'b0;

    // async reset during RUN aborts the operation
    @(negedge clk);
    if4.start       = 1'b1;
    if4.a           = 4'd9;
    if4.b           = 4'd9;
    if4.signed_mode = 1'b0;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_reset_busy", {31'b0, if4.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",    {31'b0, if4.busy}, 32'd0);
    chk("abort_done",    {31'b0, if4.done}, 32'd0);
    chk("abort_product", {24'b0, if4.product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (if4.done || if4.busy) seen = 1'b1;
    end
    chk("abort_no_activity_after", {31'b0, seen}, 32'd0);
    op4(4'd6, 4'd7, 1'b0, p4, lat);
    chk("after_abort_product", {24'b0, p4}, 32'd42);
    chk("after_abort_latency", lat, 32'd5);

    // 8-bit instance
    op8(8'd255, 8'd255, 1'b0, p8, lat);
    chk("w8_255x255",         {16'b0, p8}, 32'd65025);
    chk("w8_255x255_latency", lat, 32'd9);
    op8(8'h80, 8'h80, 1'b1, p8, lat);
    chk("w8_m128xm128",         {16'b0, p8}, 32'h4000);
    chk("w8_m128xm128_latency", lat, 32'd9);
    op8(8'h80, 8'h7F, 1'b1, p8, lat);
    chk("w8_m128x127", {16'b0, p8}, 32'hC080);
    op8(8'h80, 8'h80, 1'b0, p8, lat);
    chk("w8_128x128_unsigned", {16'b0, p8}, 32'h4000);
    op8(8'hFF, 8'h02, 1'b1, p8, lat);
    chk("w8_m1x2", {16'b0, p8}, 32'hFFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
